// File: rtl/keypad_scanner.sv
// keypad_scanner: column scanner for a 4x4 Pmod KYPD with slot-rate debounce and valid/ready key output.
// Revision 1.0 - initial release.
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEBOUNCE_N = 10
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [3:0] o_col,
  input  logic [3:0] i_row,
  output logic [3:0] o_key,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_pressed,
  output logic       o_overrun
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE_N + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_DONE   = DB_W'(DEBOUNCE_N);
  localparam logic [DB_W-1:0]   DB_REL    = DB_W'(DEBOUNCE_N - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        sync1;
  logic [3:0]        rs;
  logic [SLOT_W-1:0] slot;
  logic [DB_W-1:0]   db_cnt;
  logic [1:0]        lat_row;
  logic [1:0]        lat_col;
  logic [1:0]        low_row;
  logic              sample;
  logic              any_low;
  logic              row_low;

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    logic [1:0] idx;
    case (col_n)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign sample  = (slot == SLOT_LAST);
  assign any_low = ~&rs;
  assign row_low = ~rs[lat_row];

  // Lowest-indexed low row wins when several rows are pressed together.
  always_comb begin
    low_row = 2'd3;
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= SCAN;
      sync1     <= 4'b1111;
      rs        <= 4'b1111;
      slot      <= '0;
      db_cnt    <= '0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      o_col     <= 4'b1110;
      o_key     <= 4'h0;
      o_valid   <= 1'b0;
      o_pressed <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      sync1     <= i_row;
      rs        <= sync1;
      slot      <= sample ? '0 : slot + 1'b1;
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        SCAN: begin
          if (sample) begin
            if (any_low) begin
              lat_row <= low_row;
              lat_col <= col_index(o_col);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              o_col <= {o_col[2:0], o_col[3]};
            end
          end
        end

        DEBOUNCE: begin
          // A load overrides the accept clear above, so a same-cycle accept keeps o_valid high.
          if (db_cnt == DB_DONE) begin
            state     <= HELD;
            o_key     <= key_of(lat_row, lat_col);
            o_valid   <= 1'b1;
            o_pressed <= 1'b1;
            o_overrun <= o_valid && !i_ready;
          end else if (sample) begin
            if (row_low) begin
              db_cnt <= db_cnt + 1'b1;
            end else begin
              state <= SCAN;
              o_col <= {o_col[2:0], o_col[3]};
            end
          end
        end

        HELD: begin
          if (sample && !row_low) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end

        RELEASE: begin
          if (sample) begin
            if (row_low) begin
              state <= HELD;
            end else if (db_cnt == DB_REL) begin
              state     <= SCAN;
              o_col     <= {o_col[2:0], o_col[3]};
              o_pressed <= 1'b0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

`default_nettype wire
